// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, FSM states, instruction field positions
// and the decoded-instruction bundle passed from the field decoder to the top.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  wr_reg;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
        logic        use_rs;
        logic        use_rt;
        logic        is_jump;
    } dec_t;

endpackage

// File: rtl/instruction_decode_block_ins_field_decoder.sv
// Purely combinational instruction cracker: fields, control bits, source-use
// flags and jump/illegal classification for one 32-bit instruction.
module ins_field_decoder
    import decode_pkg::*;
(
    input  logic [31:0] ins,
    output dec_t        dec
);

    always_comb begin
        dec         = '0;
        dec.opcode  = ins[OPC_LSB +: 6];
        dec.funct   = ins[FUNCT_LSB +: 6];
        dec.rs      = ins[RS_LSB +: 5];
        dec.rt      = ins[RT_LSB +: 5];
        dec.rd      = ins[RD_LSB +: 5];
        dec.imm     = {{16{ins[IMM_LSB + 15]}}, ins[IMM_LSB +: 16]};

        case (ins[OPC_LSB +: 6])
            OP_RTYPE: begin
                dec.use_rs = 1'b1;
                dec.use_rt = 1'b1;
                dec.reg_wr = 1'b1;
                dec.wr_reg = ins[RD_LSB +: 5];
            end
            OP_ADDI: begin
                dec.use_rs = 1'b1;
                dec.reg_wr = 1'b1;
                dec.wr_reg = ins[RT_LSB +: 5];
            end
            OP_LW: begin
                dec.use_rs = 1'b1;
                dec.reg_wr = 1'b1;
                dec.mem_rd = 1'b1;
                dec.wr_reg = ins[RT_LSB +: 5];
            end
            OP_SW: begin
                dec.use_rs = 1'b1;
                dec.use_rt = 1'b1;
                dec.mem_wr = 1'b1;
            end
            OP_J:    dec.is_jump = 1'b1;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_decode_block.sv
// Decode stage: registers decoded fields and drives jump/stall feedback to fetch.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by DECODE_PERF_CNT_EN.
module instruction_decode_block
    import decode_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            reset,
`ifdef DECODE_PERF_CNT_EN
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt,
`endif
    input  logic [31:0]     ins,
    input  logic [PC_W-1:0] current_address,
    output logic [PC_W-1:0] jmp_loc,
    output logic            pc_mux_sel,
    output logic            stall,
    output logic            stall_pm,
    output logic            d_valid,
    output logic [PC_W-1:0] d_pc,
    output logic [5:0]      d_opcode,
    output logic [5:0]      d_funct,
    output logic [4:0]      d_rs,
    output logic [4:0]      d_rt,
    output logic [4:0]      d_rd,
    output logic [31:0]     d_imm,
    output logic [4:0]      d_wr_reg,
    output logic            d_reg_wr,
    output logic            d_mem_rd,
    output logic            d_mem_wr,
    output logic            d_illegal
);

    dec_t   dec;
    state_t state_q, state_d;
    logic   hazard, in_run;

    logic            d_valid_q, d_valid_d, d_reg_wr_q, d_reg_wr_d;
    logic            d_mem_rd_q, d_mem_rd_d, d_mem_wr_q, d_mem_wr_d;
    logic            d_illegal_q, d_illegal_d;
    logic [PC_W-1:0] d_pc_q, d_pc_d;
    logic [5:0]      d_opcode_q, d_opcode_d, d_funct_q, d_funct_d;
    logic [4:0]      d_rs_q, d_rs_d, d_rt_q, d_rt_d, d_rd_q, d_rd_d;
    logic [4:0]      d_wr_reg_q, d_wr_reg_d;
    logic [31:0]     d_imm_q, d_imm_d;

    ins_field_decoder u_dec (
        .ins (ins),
        .dec (dec)
    );

    // Fetch feedback is only meaningful in RUN and is forced low while in reset.
    assign in_run = (state_q == RUN) && !reset;
    assign hazard = in_run && d_valid_q && d_mem_rd_q && (d_wr_reg_q != 5'd0) &&
                    ((dec.use_rs && (dec.rs == d_wr_reg_q)) ||
                     (dec.use_rt && (dec.rt == d_wr_reg_q)));

    assign jmp_loc    = ins[PC_W-1:0];
    assign pc_mux_sel = in_run && dec.is_jump;
    assign stall      = hazard;
    assign stall_pm   = hazard;

    always_comb begin
        state_d     = state_q;
        d_valid_d   = 1'b0;
        d_reg_wr_d  = 1'b0;
        d_mem_rd_d  = 1'b0;
        d_mem_wr_d  = 1'b0;
        d_illegal_d = 1'b0;
        d_pc_d      = current_address;
        d_opcode_d  = dec.opcode;
        d_funct_d   = dec.funct;
        d_rs_d      = dec.rs;
        d_rt_d      = dec.rt;
        d_rd_d      = dec.rd;
        d_imm_d     = dec.imm;
        d_wr_reg_d  = dec.wr_reg;

        case (state_q)
            RUN: begin
                if (!hazard) begin
                    d_valid_d   = 1'b1;
                    d_reg_wr_d  = dec.reg_wr;
                    d_mem_rd_d  = dec.mem_rd;
                    d_mem_wr_d  = dec.mem_wr;
                    d_illegal_d = dec.illegal;
                end
                if (dec.is_jump) state_d = FLUSH;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT;
            d_valid_q   <= 1'b0;
            d_reg_wr_q  <= 1'b0;
            d_mem_rd_q  <= 1'b0;
            d_mem_wr_q  <= 1'b0;
            d_illegal_q <= 1'b0;
            d_pc_q      <= '0;
            d_opcode_q  <= '0;
            d_funct_q   <= '0;
            d_rs_q      <= '0;
            d_rt_q      <= '0;
            d_rd_q      <= '0;
            d_imm_q     <= '0;
            d_wr_reg_q  <= '0;
        end else begin
            state_q     <= state_d;
            d_valid_q   <= d_valid_d;
            d_reg_wr_q  <= d_reg_wr_d;
            d_mem_rd_q  <= d_mem_rd_d;
            d_mem_wr_q  <= d_mem_wr_d;
            d_illegal_q <= d_illegal_d;
            d_pc_q      <= d_pc_d;
            d_opcode_q  <= d_opcode_d;
            d_funct_q   <= d_funct_d;
            d_rs_q      <= d_rs_d;
            d_rt_q      <= d_rt_d;
            d_rd_q      <= d_rd_d;
            d_imm_q     <= d_imm_d;
            d_wr_reg_q  <= d_wr_reg_d;
        end
    end

    assign d_valid   = d_valid_q;
    assign d_reg_wr  = d_reg_wr_q;
    assign d_mem_rd  = d_mem_rd_q;
    assign d_mem_wr  = d_mem_wr_q;
    assign d_illegal = d_illegal_q;
    assign d_pc      = d_pc_q;
    assign d_opcode  = d_opcode_q;
    assign d_funct   = d_funct_q;
    assign d_rs      = d_rs_q;
    assign d_rt      = d_rt_q;
    assign d_rd      = d_rd_q;
    assign d_imm     = d_imm_q;
    assign d_wr_reg  = d_wr_reg_q;

`ifdef DECODE_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        if ((state_q == FLUSH) && (flush_cnt_q != 16'hFFFF))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_decode_block.sv
// Directed, table-driven bench for instruction_decode_block plus hand-written
// reset-during-stall/flush sequences and optional perf-counter checks.
module tb_instruction_decode_block;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins;
    logic [15:0] current_address;
    logic [15:0] jmp_loc;
    logic        pc_mux_sel, stall, stall_pm, d_valid;
    logic [15:0] d_pc;
    logic [5:0]  d_opcode, d_funct;
    logic [4:0]  d_rs, d_rt, d_rd, d_wr_reg;
    logic [31:0] d_imm;
    logic        d_reg_wr, d_mem_rd, d_mem_wr, d_illegal;
`ifdef DECODE_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    instruction_decode_block #(.PC_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
`ifdef DECODE_PERF_CNT_EN
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
`endif
        .ins             (ins),
        .current_address (current_address),
        .jmp_loc         (jmp_loc),
        .pc_mux_sel      (pc_mux_sel),
        .stall           (stall),
        .stall_pm        (stall_pm),
        .d_valid         (d_valid),
        .d_pc            (d_pc),
        .d_opcode        (d_opcode),
        .d_funct         (d_funct),
        .d_rs            (d_rs),
        .d_rt            (d_rt),
        .d_rd            (d_rd),
        .d_imm           (d_imm),
        .d_wr_reg        (d_wr_reg),
        .d_reg_wr        (d_reg_wr),
        .d_mem_rd        (d_mem_rd),
        .d_mem_wr        (d_mem_wr),
        .d_illegal       (d_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one instruction and let one edge pass, no checking.
    task automatic cyc(input logic [31:0] i, input logic [15:0] a);
        @(negedge clk);
        ins = i;
        current_address = a;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [15:0] pc;
        logic        pm;     // expected pc_mux_sel this cycle
        logic        st;     // expected stall/stall_pm this cycle
        logic        v;      // expected d_valid after the edge
        logic [4:0]  wr;
        logic        rw, mr, mw, il;
        logic [4:0]  rd;
        logic [31:0] imm;
    } vec_t;

    localparam logic [31:0] ADDI1 = 32'h20010005;
    localparam logic [31:0] LW2   = 32'h8C220000;
    localparam logic [31:0] ADD32 = 32'h00441820;

    vec_t vecs[20];

    initial begin
        vecs[0]  = '{ADDI1,         16'h0000, 0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 32'h0};
        vecs[1]  = '{ADDI1,         16'h0001, 0, 0, 1, 5'd1, 1, 0, 0, 0, 5'd0, 32'h5};
        vecs[2]  = '{32'h08000040,  16'h0003, 1, 0, 1, 5'd0, 0, 0, 0, 0, 5'd0, 32'h40};
        vecs[3]  = '{ADDI1,         16'h0004, 0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 32'h0};
        vecs[4]  = '{LW2,           16'h0040, 0, 0, 1, 5'd2, 1, 1, 0, 0, 5'd0, 32'h0};
        vecs[5]  = '{ADD32,         16'h0041, 0, 1, 0, 5'd0, 0, 0, 0, 0, 5'd0, 32'h0};
        vecs[6]  = '{ADD32,         16'h0041, 0, 0, 1, 5'd3, 1, 0, 0, 0, 5'd3, 32'h1820};
        vecs[7]  = '{32'h8C200000,  16'h0042, 0, 0, 1, 5'd0, 1, 1, 0, 0, 5'd0, 32'h0};
        vecs[8]  = '{32'h00041820,  16'h0043, 0, 0, 1, 5'd3, 1, 0, 0, 0, 5'd3, 32'h1820};
        vecs[9]  = '{LW2,           16'h0044, 0, 0, 1, 5'd2, 1, 1, 0, 0, 5'd0, 32'h0};
        vecs[10] = '{32'hAC450000,  16'h0045, 0, 1, 0, 5'd0, 0, 0, 0, 0, 5'd0, 32'h0};
        vecs[11] = '{32'hAC450000,  16'h0045, 0, 0, 1, 5'd0, 0, 0, 1, 0, 5'd0, 32'h0};
        vecs[12] = '{LW2,           16'h0046, 0, 0, 1, 5'd2, 1, 1, 0, 0, 5'd0, 32'h0};
        vecs[13] = '{32'h08000080,  16'h0047, 1, 0, 1, 5'd0, 0, 0, 0, 0, 5'd0, 32'h80};
        vecs[14] = '{ADD32,         16'h0048, 0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 32'h0};
        vecs[15] = '{32'hFC000000,  16'h0080, 0, 0, 1, 5'd0, 0, 0, 0, 1, 5'd0, 32'h0};
        vecs[16] = '{LW2,           16'h0081, 0, 0, 1, 5'd2, 1, 1, 0, 0, 5'd0, 32'h0};
        vecs[17] = '{32'h8CE60000,  16'h0082, 0, 0, 1, 5'd6, 1, 1, 0, 0, 5'd0, 32'h0};
        vecs[18] = '{ADD32,         16'h0083, 0, 0, 1, 5'd3, 1, 0, 0, 0, 5'd3, 32'h1820};
        vecs[19] = '{32'h2001FFFF,  16'h0084, 0, 0, 1, 5'd1, 1, 0, 0, 0, 5'd31, 32'hFFFFFFFF};

        reset = 1'b1;
        ins = ADDI1;
        current_address = 16'h0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_valid",  {31'b0, d_valid}, 32'h0);
        chk("rst_wr_reg", {27'b0, d_wr_reg}, 32'h0);
        chk("rst_imm",    d_imm, 32'h0);
        chk("rst_pc",     {16'b0, d_pc}, 32'h0);
        chk("rst_ctrl",   {28'b0, d_reg_wr, d_mem_rd, d_mem_wr, d_illegal}, 32'h0);
        chk("rst_fetch",  {29'b0, pc_mux_sel, stall, stall_pm}, 32'h0);
        chk("rst_jmp_loc", {16'b0, jmp_loc}, 32'h0005);

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            reset = 1'b0;
            ins = vecs[k].ins;
            current_address = vecs[k].pc;
            #1;
            chk($sformatf("v%0d_pc_mux_sel", k), {31'b0, pc_mux_sel}, {31'b0, vecs[k].pm});
            chk($sformatf("v%0d_stall", k), {30'b0, stall, stall_pm}, {30'b0, vecs[k].st, vecs[k].st});
            chk($sformatf("v%0d_jmp_loc", k), {16'b0, jmp_loc}, {16'b0, vecs[k].ins[15:0]});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", k), {31'b0, d_valid}, {31'b0, vecs[k].v});
            chk($sformatf("v%0d_ctrl", k), {28'b0, d_reg_wr, d_mem_rd, d_mem_wr, d_illegal},
                {28'b0, vecs[k].rw, vecs[k].mr, vecs[k].mw, vecs[k].il});
            if (vecs[k].v) begin
                chk($sformatf("v%0d_wr_reg", k), {27'b0, d_wr_reg}, {27'b0, vecs[k].wr});
                chk($sformatf("v%0d_rd", k), {27'b0, d_rd}, {27'b0, vecs[k].rd});
                chk($sformatf("v%0d_imm", k), d_imm, vecs[k].imm);
                chk($sformatf("v%0d_d_pc", k), {16'b0, d_pc}, {16'b0, vecs[k].pc});
                chk($sformatf("v%0d_opcode", k), {26'b0, d_opcode}, {26'b0, vecs[k].ins[31:26]});
            end
        end

        // Reset asserted during a load-use stall.
        cyc(LW2, 16'h0100);
        @(negedge clk);
        ins = ADD32;
        current_address = 16'h0101;
        #1;
        chk("mid_stall_stall", {31'b0, stall}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_stall_valid", {31'b0, d_valid}, 32'h0);
        chk("mid_stall_fields", {d_wr_reg, d_rd, d_opcode, d_pc[15:0]}, 32'h0);
        chk("mid_stall_ctrl", {28'b0, d_reg_wr, d_mem_rd, d_mem_wr, d_illegal}, 32'h0);
        chk("mid_stall_imm", d_imm, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ins = ADDI1;
        current_address = 16'h0200;
        @(posedge clk); #1;
        chk("post_rst_wait_bubble", {31'b0, d_valid}, 32'h0);
        cyc(ADDI1, 16'h0201);
        chk("post_rst_run_valid", {31'b0, d_valid}, 32'h1);

        // Reset asserted during the flush cycle after a jump.
        cyc(32'h08000010, 16'h0202);
        @(negedge clk);
        ins = ADDI1;
        current_address = 16'h0203;
        #1;
        chk("mid_flush_fetch", {30'b0, pc_mux_sel, stall}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_flush_valid", {31'b0, d_valid}, 32'h0);
        chk("mid_flush_pc", {16'b0, d_pc}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_flush_wait_bubble", {31'b0, d_valid}, 32'h0);

`ifdef DECODE_PERF_CNT_EN
        cyc(ADDI1, 16'h0300);
        chk("cnt_start_stall", {16'b0, stall_cnt}, 32'h0);
        for (int h = 0; h < 3; h++) begin
            cyc(LW2, 16'h0300);
            cyc(ADD32, 16'h0301);
            cyc(ADD32, 16'h0301);
        end
        cyc(32'h08000020, 16'h0302);
        cyc(ADDI1, 16'h0303);
        chk("cnt_stall_3", {16'b0, stall_cnt}, 32'd3);
        chk("cnt_flush_1", {16'b0, flush_cnt}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("cnt_stall_rst", {16'b0, stall_cnt}, 32'h0);
        chk("cnt_flush_rst", {16'b0, flush_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
